// File: rtl/neander_mmio_pkg.sv
// Shared NEANDER-X MMIO definitions: input-capture register map, control and
// status bit positions, and the capture edge selector.
package neander_mmio_pkg;

  localparam logic [15:0] CAP_CTRL_ADDR   = 16'hF030;
  localparam logic [15:0] CAP_DIV_ADDR    = 16'hF032;
  localparam logic [15:0] CAP_VALUE_ADDR  = 16'hF034;
  localparam logic [15:0] CAP_PERIOD_ADDR = 16'hF036;
  localparam logic [15:0] CAP_COUNT_ADDR  = 16'hF038;
  localparam logic [15:0] CAP_STATUS_ADDR = 16'hF03A;

  localparam int unsigned CTRL_ENABLE     = 0;
  localparam int unsigned CTRL_CLEAR      = 1;
  localparam int unsigned CTRL_IRQ_EN     = 2;
  localparam int unsigned CTRL_EDGE_LO    = 3;
  localparam int unsigned CTRL_EDGE_HI    = 4;
  localparam int unsigned CTRL_OVF_IRQ_EN = 5;

  localparam int unsigned ST_CAP     = 0;
  localparam int unsigned ST_OVR     = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_PVALID  = 3;
  localparam int unsigned ST_LEVEL   = 4;
  localparam int unsigned ST_RUNNING = 5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_t;

endpackage

// File: rtl/input_capture_filter.sv
// Synchronizer, glitch filter and edge detector for the capture pin.
// level flips after FILTER_LEN consecutive differing samples; rise/fall pulse with it.
module input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cap_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          run_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      run_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sample == level) begin
        run_q <= '0;
      end else if (run_q == CW'(FILTER_LEN - 1)) begin
        level <= sample;
        rise  <= sample;
        fall  <= ~sample;
        run_q <= '0;
      end else begin
        run_q <= run_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_capture.sv
// Input-capture timer: prescaled 16-bit counter latched on filtered pin edges,
// with period measurement, sticky W1C flags and an interrupt output.
module input_capture
  import neander_mmio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cap_ctrl,
  input  logic [15:0] cap_div,
  input  logic        status_wr,
  input  logic [15:0] status_wdata,
  input  logic        cap_in,
  output logic [15:0] cap_value,
  output logic [15:0] cap_period,
  output logic [15:0] cap_count,
  output logic [15:0] cap_status,
  output logic        cap_irq
);

  logic level, rise, fall;

  input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .cap_in (cap_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  logic      enable, clear, irq_en, ovf_irq_en;
  edge_sel_t edge_sel;
  logic      unused_bits;

  assign enable      = cap_ctrl[CTRL_ENABLE];
  assign clear       = cap_ctrl[CTRL_CLEAR];
  assign irq_en      = cap_ctrl[CTRL_IRQ_EN];
  assign ovf_irq_en  = cap_ctrl[CTRL_OVF_IRQ_EN];
  assign edge_sel    = edge_sel_t'(cap_ctrl[CTRL_EDGE_HI:CTRL_EDGE_LO]);
  assign unused_bits = ^{cap_ctrl[15:6], status_wdata[15:3]};

  logic [15:0] div_q, count_q, value_q, period_q, prev_q;
  logic        has_prev_q, pvalid_q, cap_q, ovr_q, ovf_q, running_q;

  logic [15:0] eff_div;
  logic        tick, wrap, match, event_cap;
  logic        ack_cap, ack_ovr, ack_ovf;

  assign eff_div   = (cap_div == '0) ? 16'd1 : cap_div;
  assign tick      = enable && (div_q == eff_div - 16'd1);
  assign wrap      = tick && (count_q == '1);
  assign event_cap = enable && !clear && match;
  assign ack_cap   = status_wr && status_wdata[ST_CAP];
  assign ack_ovr   = status_wr && status_wdata[ST_OVR];
  assign ack_ovf   = status_wr && status_wdata[ST_OVF];

  always_comb begin
    match = 1'b0;
    case (edge_sel)
      EDGE_RISE: match = rise;
      EDGE_FALL: match = fall;
      EDGE_BOTH: match = rise | fall;
      default:   match = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      div_q      <= '0;
      count_q    <= '0;
      value_q    <= '0;
      period_q   <= '0;
      prev_q     <= '0;
      has_prev_q <= 1'b0;
      pvalid_q   <= 1'b0;
      cap_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      running_q  <= reset_n ? enable : 1'b0;
    end else begin
      running_q <= enable;
      div_q     <= (!enable || tick) ? '0 : div_q + 16'd1;
      if (tick) count_q <= count_q + 16'd1;
      if (event_cap) begin
        value_q    <= count_q;
        prev_q     <= count_q;
        period_q   <= has_prev_q ? count_q - prev_q : '0;
        has_prev_q <= 1'b1;
        if (has_prev_q) pvalid_q <= 1'b1;
      end
      // Set events take priority over a coincident W1C so none is lost.
      cap_q <= event_cap | (cap_q & ~ack_cap);
      ovr_q <= (event_cap & cap_q) | (ovr_q & ~ack_ovr);
      ovf_q <= wrap | (ovf_q & ~ack_ovf);
    end
  end

  assign cap_value  = value_q;
  assign cap_period = period_q;
  assign cap_count  = count_q;
  assign cap_irq    = irq_en && (cap_q || (ovf_irq_en && ovf_q));

  always_comb begin
    cap_status             = '0;
    cap_status[ST_CAP]     = cap_q;
    cap_status[ST_OVR]     = ovr_q;
    cap_status[ST_OVF]     = ovf_q;
    cap_status[ST_PVALID]  = pvalid_q;
    cap_status[ST_LEVEL]   = level;
    cap_status[ST_RUNNING] = running_q;
  end

endmodule

// File: tb/tb_input_capture.sv
// Bench for input_capture: directed scenarios plus randomized pin/control traffic,
// every cycle compared against a pin-history based reference model.
module tb_input_capture;
  import neander_mmio_pkg::*;

  localparam int unsigned S  = 2;
  localparam int unsigned FL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cap_ctrl = '0;
  logic [15:0] cap_div = '0;
  logic        status_wr = 1'b0;
  logic [15:0] status_wdata = '0;
  logic        cap_in = 1'b0;
  logic [15:0] cap_value, cap_period, cap_count, cap_status;
  logic        cap_irq;

  always #5 clk = ~clk;

  input_capture #(
    .SYNC_STAGES(S),
    .FILTER_LEN (FL)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cap_ctrl    (cap_ctrl),
    .cap_div     (cap_div),
    .status_wr   (status_wr),
    .status_wdata(status_wdata),
    .cap_in      (cap_in),
    .cap_value   (cap_value),
    .cap_period  (cap_period),
    .cap_count   (cap_count),
    .cap_status  (cap_status),
    .cap_irq     (cap_irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          per_cycle = 1'b1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  bit          hist[$];
  bit          m_level, m_rise, m_fall, m_cap, m_ovr, m_ovf, m_run;
  logic [15:0] m_div, m_count, m_value, m_period, m_last;
  int unsigned m_ncap;

  task automatic model_clear();
    m_div = '0; m_count = '0; m_value = '0; m_period = '0; m_last = '0;
    m_ncap = 0; m_cap = 0; m_ovr = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit          en, clr, ev, tick, wrap, old_cap, all_diff;
    logic [1:0]  es;
    logic [15:0] effd;
    if (!reset_n) begin
      model_clear();
      hist.delete();
      for (int i = 0; i < int'(S + FL); i++) hist.push_back(1'b0);
      m_level = 0; m_rise = 0; m_fall = 0; m_run = 0;
      return;
    end
    en   = cap_ctrl[0];
    clr  = cap_ctrl[1];
    es   = cap_ctrl[4:3];
    ev   = en && !clr && ((es == 2'b00 && m_rise) || (es == 2'b01 && m_fall) ||
                          (es == 2'b10 && (m_rise || m_fall)));
    effd = (cap_div == 16'd0) ? 16'd1 : cap_div;
    tick = en && !clr && (m_div == effd - 16'd1);
    wrap = tick && (m_count == 16'hFFFF);
    if (clr) begin
      model_clear();
    end else begin
      old_cap = m_cap;
      if (status_wr && status_wdata[0]) m_cap = 0;
      if (status_wr && status_wdata[1]) m_ovr = 0;
      if (status_wr && status_wdata[2]) m_ovf = 0;
      if (ev) begin
        if (old_cap) m_ovr = 1;
        m_cap    = 1;
        m_value  = m_count;
        m_period = (m_ncap == 0) ? 16'd0 : m_count - m_last;
        m_last   = m_count;
        m_ncap++;
      end
      if (wrap) m_ovf = 1;
      m_div = (!en || tick) ? 16'd0 : m_div + 16'd1;
      if (tick) m_count = m_count + 16'd1;
    end
    m_run = en;
    // Oldest FL entries are the synchronized samples the filter has seen lately.
    hist.push_back(cap_in);
    if (hist.size() > S + FL) void'(hist.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < int'(FL); i++) if (hist[i] == m_level) all_diff = 1'b0;
    m_rise = all_diff && !m_level;
    m_fall = all_diff && m_level;
    if (all_diff) m_level = !m_level;
  endtask

  task automatic check_all();
    logic [15:0] st;
    bit          irq;
    st  = {10'b0, m_run, m_level, (m_ncap >= 2), m_ovf, m_ovr, m_cap};
    irq = cap_ctrl[2] && (m_cap || (cap_ctrl[5] && m_ovf));
    check("cap_value", cap_value, m_value);
    check("cap_period", cap_period, m_period);
    check("cap_count", cap_count, m_count);
    check("cap_status", cap_status, st);
    check("cap_irq", {15'b0, cap_irq}, {15'b0, irq});
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      if (per_cycle) check_all();
    end
  endtask

  initial begin
    int unsigned r;
    // Reset
    run(3);
    check("rst_status", cap_status, 16'h0000);
    check("rst_count", cap_count, 16'h0000);
    reset_n = 1'b1;

    // div=0, rising edges 100 clocks apart
    cap_ctrl = 16'h0001; cap_div = 16'd0;
    run(10);
    for (int p = 0; p < 3; p++) begin
      cap_in = 1'b1; run(50);
      if (p == 0) begin
        check("first_period", cap_period, 16'd0);
        check("first_pvalid", {15'b0, cap_status[ST_PVALID]}, 16'd0);
        check("first_cap", {15'b0, cap_status[ST_CAP]}, 16'd1);
      end
      cap_in = 1'b0; run(50);
    end
    check("period_100", cap_period, 16'd100);
    check("pvalid_set", {15'b0, cap_status[ST_PVALID]}, 16'd1);

    // div=4, both edges, 40-clock pulse
    cap_ctrl = 16'h0003; run(1);
    cap_ctrl = 16'h0011; cap_div = 16'd4;
    run(10);
    cap_in = 1'b1; run(40);
    cap_in = 1'b0; run(20);
    check("period_div4", cap_period, 16'd10);
    check("ovr_two_caps", {15'b0, cap_status[ST_OVR]}, 16'd1);
    // W1C coincident with a third capture
    cap_in = 1'b1; run(5);
    status_wr = 1'b1; status_wdata = 16'h0003; run(1);
    status_wr = 1'b0;
    check("w1c_vs_event", {14'b0, cap_status[1:0]}, 16'h0003);
    status_wr = 1'b1; run(1);
    status_wr = 1'b0;
    check("w1c_plain", {14'b0, cap_status[1:0]}, 16'h0000);
    cap_in = 1'b0; run(10);

    // Glitch rejection and capture latency
    cap_ctrl = 16'h0003; run(1);
    cap_ctrl = 16'h0001; cap_div = 16'd0;
    run(10);
    cap_in = 1'b1; run(2);
    cap_in = 1'b0; run(10);
    check("glitch_cap", {15'b0, cap_status[ST_CAP]}, 16'd0);
    check("glitch_level", {15'b0, cap_status[ST_LEVEL]}, 16'd0);
    cap_in = 1'b1; run(3);
    cap_in = 1'b0; run(2);
    check("latency_early", {15'b0, cap_status[ST_CAP]}, 16'd0);
    run(1);
    check("latency_exact", {15'b0, cap_status[ST_CAP]}, 16'd1);
    run(10);

    // Counter wrap and OVF interrupt
    cap_ctrl = 16'h0003; run(1);
    cap_ctrl = 16'h0019; cap_div = 16'd0;
    per_cycle = 1'b0;
    run(65520);
    per_cycle = 1'b1;
    check("count_fff0", cap_count, 16'hFFF0);
    run(15);
    check("ovf_before", {15'b0, cap_status[ST_OVF]}, 16'd0);
    run(1);
    check("ovf_after", {15'b0, cap_status[ST_OVF]}, 16'd1);
    check("count_wrapped", cap_count, 16'h0000);
    cap_ctrl = 16'h003D; run(1);
    check("ovf_irq", {15'b0, cap_irq}, 16'd1);
    status_wr = 1'b1; status_wdata = 16'h0004; run(1);
    status_wr = 1'b0;
    check("ovf_irq_ack", {15'b0, cap_irq}, 16'd0);

    // CLEAR against a capture, then reset mid-pulse
    cap_ctrl = 16'h0003; run(1);
    cap_ctrl = 16'h0001;
    run(10);
    cap_in = 1'b1; run(5);
    cap_ctrl = 16'h0003; run(1);
    cap_ctrl = 16'h0001;
    check("clear_drops_cap", {15'b0, cap_status[ST_CAP]}, 16'd0);
    run(3);
    reset_n = 1'b0; cap_ctrl = 16'h0000; run(2);
    check("rst_mid_status", cap_status, 16'h0000);
    check("rst_mid_value", cap_value, 16'h0000);
    reset_n = 1'b1; cap_ctrl = 16'h0001; run(12);
    check("post_rst_cap", {15'b0, cap_status[ST_CAP]}, 16'd1);
    cap_in = 1'b0; run(10);

    // Randomized traffic
    repeat (400) begin
      r            = $urandom_range(99, 0);
      cap_in       = 1'($urandom_range(1, 0));
      cap_div      = 16'($urandom_range(3, 0));
      cap_ctrl     = {10'b0, 1'($urandom), 2'($urandom), 1'($urandom), 1'(r < 4), 1'(r < 90)};
      status_wr    = ($urandom_range(3, 0) == 0);
      status_wdata = 16'($urandom_range(7, 0));
      reset_n      = (r != 99);
      run($urandom_range(8, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_capture.md
# input_capture

Input-capture peripheral for the NEANDER-X interconnect. It is the input-side counterpart of the compare/output timer: it timestamps edges on an external pin instead of generating them. A prescaled 16-bit free-running counter is latched on selected edges of a synchronized, glitch-filtered input. The block reports the capture value, the period between successive captures, sticky W1C flags and an IRQ. The MMIO decoder sits outside this block (CAP_CTRL 0xF030, CAP_DIV 0xF032, CAP_VALUE 0xF034, CAP_PERIOD 0xF036, CAP_COUNT 0xF038, CAP_STATUS 0xF03A).

## Interface
- SYNC_STAGES, 2, synchronizer depth on cap_in (≥2)
- FILTER_LEN, 3, consecutive equal synchronized samples needed to accept a level change (≥1)
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- cap_ctrl  in  16  [0] ENABLE, [1] CLEAR, [2] IRQ_EN, [4:3] EDGE (00 rise, 01 fall, 10 both, 11 none), [5] OVF_IRQ_EN
- cap_div  in  16  prescaler divider; 0 is treated as 1
- status_wr  in  1  one-cycle write strobe to CAP_STATUS
- status_wdata  in  16  W1C mask: [0] CAP, [1] OVR, [2] OVF
- cap_in  in  1  asynchronous external pin
- cap_value  out  16  counter value at the last capture
- cap_period  out  16  (cap_value − previous capture) mod 2^16
- cap_count  out  16  live counter
- cap_status  out  16  [0] CAP, [1] OVR, [2] OVF, [3] PVALID, [4] LEVEL (filtered pin), [5] RUNNING (=ENABLE), rest 0
- cap_irq  out  1  IRQ_EN && (CAP || (OVF_IRQ_EN && OVF))

## Operation
- Input path: SYNC_STAGES flops, then the filter. Filtered LEVEL changes only after FILTER_LEN consecutive synchronized samples differ from the current LEVEL. The filter runs whenever the block is out of reset, independent of ENABLE, so enabling never produces a false edge.
- Prescaler: div_counter counts 0..eff_div−1; tick when it equals eff_div−1. It is held at 0 while !ENABLE or CLEAR.
- Counter: increments on each tick while ENABLE. It wraps 0xFFFF→0x0000; the wrap sets OVF. It holds while disabled.
- Capture event: ENABLE && a filtered edge matching EDGE. On the event:
  - cap_value ← cap_count (the pre-increment value of that cycle)
  - cap_period ← cap_count − prev, 16-bit wrap
  - prev ← cap_count
  - CAP set
  - If this is the first capture since reset or CLEAR: cap_period ← 0 and PVALID stays 0. PVALID is set from the second capture on.
- Overrun: a capture while CAP is already 1 sets OVR. cap_value and cap_period are overwritten with the newest event.
- W1C: status_wr clears the flags whose mask bits are 1. A set event in the same cycle wins, so no event is lost. PVALID, LEVEL and RUNNING are read-only.
- CLEAR (level-sensitive, asserted by software for one cycle) zeroes the counter, prescaler, cap_value, cap_period, prev, PVALID, CAP, OVR and OVF. A capture in the same cycle is discarded.
- EDGE=11: no captures; the counter still runs.

## Timing
- Reset (reset_n low at a clk edge) zeroes every register. All outputs are 0 after that edge; LEVEL resets to 0.
- Pin-to-capture latency: a pin change first sampled at edge N updates cap_value/CAP at edge N+SYNC_STAGES+FILTER_LEN (5 with defaults). The latency is constant, so periods are exact.
- Pulses shorter than FILTER_LEN clocks after synchronization are rejected.
- cap_irq is combinational from registered flags; it asserts the cycle after the capture edge.
- reset_n low mid-pulse: all state is lost. After release, a pin that is already high produces a rising LEVEL change after the pipeline fills. It captures only if ENABLE is already set.

## Structure
- Shared package neander_mmio_pkg holds:
  - CAP_* register address constants
  - control and status bit-position localparams
  - edge_sel_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE)
- Sub-module input_filter (parameters SYNC_STAGES, FILTER_LEN) contains the synchronizer, filter and edge detect. It outputs level, rise and fall.
- input_capture holds the prescaler, counter, capture/period registers, flags and the IRQ.

## Test plan
- div=0, EDGE=rise, ENABLE: rising pin edges 100 clocks apart → cap_period=100 from the second capture, PVALID=1, first cap_period=0.
- div=4, EDGE=both, 40-clock high pulse → two captures, cap_period=10.
- Glitch: 2-clock high pulse with FILTER_LEN=3 → no capture, LEVEL stays 0. A 3-clock pulse → capture at the documented latency.
- Two captures without ack → OVR=1, cap_value = second timestamp. W1C of 0x3 in the same cycle as a third capture → CAP=1, OVR=1 remain set.
- Counter runs from 0xFFF0 with div=1 → OVF after 16 ticks; OVF_IRQ_EN|IRQ_EN → cap_irq=1; W1C 0x4 → cap_irq=0.
- CLEAR coincident with a capture, then reset_n low mid-pulse → all registers 0, no capture recorded, cap_status=0.
